// File: rtl/vid_bytestream_src.sv
// vid_bytestream_src: packs an LSB-first byte stream into pixels and plays them out as a timed di/de/hs/vs video stream.
// Optional build macro VID_SRC_STALL_EN: a missing pixel stalls the active line instead of emitting a blank pixel.
`default_nettype none
module vid_bytestream_src #(
  parameter int PIXEL_BYTES = 3,
  parameter int DIM_W       = 13,
  parameter int FRM_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DIM_W-1:0]         cfg_width,
  input  logic [DIM_W-1:0]         cfg_height,
  input  logic [DIM_W-1:0]         cfg_hblank,
  input  logic [DIM_W-1:0]         cfg_vblank,
  input  logic [FRM_W-1:0]         cfg_frames,
  input  logic                     start,
  input  logic [7:0]               s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [8*PIXEL_BYTES-1:0] di_o,
  output logic                     de_o,
  output logic                     hs_o,
  output logic                     vs_o,
  output logic                     busy,
  output logic                     done,
  output logic                     underrun
);
  localparam int PW   = 8 * PIXEL_BYTES;
  localparam int BC_W = (PIXEL_BYTES > 1) ? $clog2(PIXEL_BYTES) : 1;
  localparam logic [BC_W-1:0]  BC_LAST = BC_W'(PIXEL_BYTES - 1);
  localparam logic [DIM_W-1:0] DIM_ONE = DIM_W'(1);
  localparam logic [FRM_W-1:0] FRM_ONE = FRM_W'(1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_VBLANK = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;
  localparam logic [1:0] S_HBLANK = 2'd3;

  logic [1:0]       state;
  logic [DIM_W-1:0] cnt, line;
  logic [DIM_W-1:0] l_width, l_height, l_hblank, l_vblank;
  logic [FRM_W-1:0] frame_cnt, l_frames;
  logic             fin, run;

  logic [BC_W-1:0]  bcnt;
  logic [PW-1:0]    asm_q, asm_full, pix;
  logic             pix_vld;

  logic             consume, byte_last, accept, advance;
  logic [DIM_W-1:0] hb_eff;
  logic [FRM_W-1:0] frame_nxt;
  logic [1:0]       frame_entry;

  assign consume     = (state == S_ACTIVE) && pix_vld;
  assign byte_last   = (bcnt == BC_LAST);
  // run keeps s_ready low for the cycle a reset is being applied.
  assign s_ready     = run && (!byte_last || !pix_vld || consume);
  assign accept      = s_valid && s_ready;
  assign hb_eff      = (l_hblank == '0) ? DIM_ONE : l_hblank;
  assign frame_nxt   = frame_cnt + FRM_ONE;
  assign frame_entry = (l_vblank == '0) ? S_ACTIVE : S_VBLANK;

`ifdef VID_SRC_STALL_EN
  assign advance = pix_vld;
`else
  assign advance = 1'b1;
`endif

  always_comb begin
    asm_full = asm_q;
    asm_full[{bcnt, 3'b000} +: 8] = s_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bcnt    <= '0;
      asm_q   <= '0;
      pix     <= '0;
      pix_vld <= 1'b0;
    end else if (accept && byte_last) begin
      // A consume in the same cycle is covered: the new pixel replaces it.
      pix     <= asm_full;
      pix_vld <= 1'b1;
      bcnt    <= '0;
    end else begin
      if (consume) pix_vld <= 1'b0;
      if (accept) begin
        asm_q <= asm_full;
        bcnt  <= bcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      line      <= '0;
      frame_cnt <= '0;
      l_width   <= '0;
      l_height  <= '0;
      l_hblank  <= '0;
      l_vblank  <= '0;
      l_frames  <= '0;
      fin       <= 1'b0;
      run       <= 1'b0;
    end else begin
      run <= 1'b1;
      fin <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          l_width   <= cfg_width;
          l_height  <= cfg_height;
          l_hblank  <= cfg_hblank;
          l_vblank  <= cfg_vblank;
          l_frames  <= cfg_frames;
          cnt       <= '0;
          line      <= '0;
          frame_cnt <= '0;
          state     <= (cfg_vblank == '0) ? S_ACTIVE : S_VBLANK;
        end
        S_VBLANK: if (cnt == l_vblank - DIM_ONE) begin
          cnt   <= '0;
          state <= S_ACTIVE;
        end else cnt <= cnt + DIM_ONE;
        S_ACTIVE: if (advance) begin
          if (cnt == l_width - DIM_ONE) begin
            cnt   <= '0;
            state <= S_HBLANK;
          end else cnt <= cnt + DIM_ONE;
        end
        S_HBLANK: if (cnt == hb_eff - DIM_ONE) begin
          cnt <= '0;
          if (line == l_height - DIM_ONE) begin
            line      <= '0;
            frame_cnt <= frame_nxt;
            if (l_frames != '0 && frame_nxt == l_frames) begin
              state <= S_IDLE;
              fin   <= 1'b1;
            end else state <= frame_entry;
          end else begin
            line  <= line + DIM_ONE;
            state <= S_ACTIVE;
          end
        end else cnt <= cnt + DIM_ONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output stage shows the role of the previous cycle's state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_o     <= 1'b0;
      hs_o     <= 1'b0;
      de_o     <= 1'b0;
      di_o     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      vs_o <= (state == S_VBLANK);
      hs_o <= (state == S_HBLANK);
      de_o <= (state == S_ACTIVE) && advance;
      di_o <= consume ? pix : '0;
      busy <= (state != S_IDLE);
      done <= fin;
      if (state == S_IDLE && start)           underrun <= 1'b0;
      else if (state == S_ACTIVE && !pix_vld) underrun <= 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_vid_bytestream_src.sv
// tb_vid_bytestream_src: directed table checks of vid_bytestream_src with PIXEL_BYTES=1 (dut_a) and PIXEL_BYTES=3 (dut_b).
`timescale 1ns/1ps
`default_nettype none
module tb_vid_bytestream_src;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [12:0] cfg_width, cfg_height, cfg_hblank, cfg_vblank;
  logic [15:0] cfg_frames;
  logic        start_a, start_b;
  logic [7:0]  sd_a, sd_b;
  logic        sv_a, sv_b, sr_a, sr_b;
  logic [7:0]  di_a;
  logic [23:0] di_b;
  logic        de_a, hs_a, vs_a, busy_a, done_a, ur_a;
  logic        de_b, hs_b, vs_b, busy_b, done_b, ur_b;

  vid_bytestream_src #(.PIXEL_BYTES(1), .DIM_W(13), .FRM_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .cfg_hblank(cfg_hblank), .cfg_vblank(cfg_vblank), .cfg_frames(cfg_frames),
    .start(start_a), .s_data(sd_a), .s_valid(sv_a), .s_ready(sr_a),
    .di_o(di_a), .de_o(de_a), .hs_o(hs_a), .vs_o(vs_a),
    .busy(busy_a), .done(done_a), .underrun(ur_a));

  vid_bytestream_src #(.PIXEL_BYTES(3), .DIM_W(13), .FRM_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .cfg_hblank(cfg_hblank), .cfg_vblank(cfg_vblank), .cfg_frames(cfg_frames),
    .start(start_b), .s_data(sd_b), .s_valid(sv_b), .s_ready(sr_b),
    .di_o(di_b), .de_o(de_b), .hs_o(hs_b), .vs_o(vs_b),
    .busy(busy_b), .done(done_b), .underrun(ur_b));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Byte feeders: a queue per DUT; acceptance is decided at the negedge before the edge.
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  logic fe_a = 1'b1, fe_b = 1'b1;
  logic acc_a = 1'b0, acc_b = 1'b0;
  int   nacc_b = 0;

  always @(negedge clk) begin
    acc_a = sv_a && sr_a;
    acc_b = sv_b && sr_b;
  end

  initial begin
    sv_a = 1'b0; sd_a = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (acc_a) void'(q_a.pop_front());
      if (fe_a && q_a.size() > 0) begin sv_a = 1'b1; sd_a = q_a[0]; end
      else begin sv_a = 1'b0; sd_a = 8'h00; end
    end
  end

  initial begin
    sv_b = 1'b0; sd_b = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (acc_b) begin void'(q_b.pop_front()); nacc_b++; end
      if (fe_b && q_b.size() > 0) begin sv_b = 1'b1; sd_b = q_b[0]; end
      else begin sv_b = 1'b0; sd_b = 8'h00; end
    end
  end

  typedef struct {
    logic        busy, done, vs, hs, de;
    logic [23:0] di;
    logic        st;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input int n, input logic vs, input logic hs, input logic de,
                     input logic [23:0] di0, input logic [23:0] step);
    for (int i = 0; i < n; i++) begin
      vec_t v;
      v.busy = 1'b1; v.done = 1'b0; v.vs = vs; v.hs = hs; v.de = de; v.st = 1'b0;
      v.di = di0 + step * 24'(i);
      tbl.push_back(v);
    end
  endtask

  task automatic add_done();
    vec_t v;
    v.busy = 1'b0; v.done = 1'b1; v.vs = 1'b0; v.hs = 1'b0; v.de = 1'b0;
    v.di = 24'h0; v.st = 1'b0;
    tbl.push_back(v);
  endtask

  // 4x2 frame, hblank 2, vblank 3; line pixels l1, l1+1.. and l2, l2+1..
  task automatic add_frame_a(input logic [23:0] l1, input logic [23:0] l2, input logic [23:0] step);
    add(3, 1'b1, 1'b0, 1'b0, 24'h0, 24'h0);
    add(4, 1'b0, 1'b0, 1'b1, l1, step);
    add(2, 1'b0, 1'b1, 1'b0, 24'h0, 24'h0);
    add(4, 1'b0, 1'b0, 1'b1, l2, step);
    add(2, 1'b0, 1'b1, 1'b0, 24'h0, 24'h0);
  endtask

  // 1x2 frame, hblank 2, vblank 3 for the 3-byte DUT.
  task automatic add_frame_b(input logic [23:0] p1, input logic [23:0] p2);
    add(3, 1'b1, 1'b0, 1'b0, 24'h0, 24'h0);
    add(1, 1'b0, 1'b0, 1'b1, p1, 24'h0);
    add(2, 1'b0, 1'b1, 1'b0, 24'h0, 24'h0);
    add(1, 1'b0, 1'b0, 1'b1, p2, 24'h0);
    add(2, 1'b0, 1'b1, 1'b0, 24'h0, 24'h0);
  endtask

  task automatic run_table(input bit use_b, input string tag);
    logic [63:0] got, exp;
    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); @(negedge clk);
      if (use_b) got = {35'h0, busy_b, done_b, vs_b, hs_b, de_b, di_b};
      else       got = {35'h0, busy_a, done_a, vs_a, hs_a, de_a, 16'h0, di_a};
      exp = {35'h0, tbl[i].busy, tbl[i].done, tbl[i].vs, tbl[i].hs, tbl[i].de, tbl[i].di};
      chk($sformatf("%s[%0d]", tag, i), got, exp);
      if (use_b) start_b = tbl[i].st; else start_a = tbl[i].st;
    end
    tbl.delete();
  endtask

  task automatic pulse_start(input bit use_b);
    @(posedge clk); #1;
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
  endtask

  task automatic set_cfg(input int w, input int h, input int hb, input int vb, input int fr);
    cfg_width = 13'(w); cfg_height = 13'(h); cfg_hblank = 13'(hb);
    cfg_vblank = 13'(vb); cfg_frames = 16'(fr);
  endtask

  initial begin
    int nd;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    set_cfg(4, 2, 2, 3, 1);
    for (int i = 1; i <= 8; i++) q_a.push_back(8'(i));
    for (int i = 1; i <= 30; i++) q_b.push_back(8'(i));

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_a", {sr_a, busy_a, done_a, vs_a, hs_a, de_a, ur_a, di_a}, 64'h0);
    chk("reset_b", {sr_b, busy_b, done_b, vs_b, hs_b, de_b, ur_b, di_b}, 64'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Backpressure: 3-byte DUT holds one pixel plus two assembled bytes.
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("bp_accepted", 64'(nacc_b), 64'd5);
    chk("bp_ready", {63'h0, sr_b}, 64'h0);

    // One frame, continuous supply.
    add_frame_a(24'h01, 24'h05, 24'h1);
    add_done();
    pulse_start(1'b0);
    run_table(1'b0, "frame1");
    chk("frame1_underrun", {63'h0, ur_a}, 64'h0);

    // Two frames back to back.
    for (int i = 0; i < 8; i++) q_a.push_back(8'h11 + 8'(i));
    for (int i = 0; i < 8; i++) q_a.push_back(8'h21 + 8'(i));
    set_cfg(4, 2, 2, 3, 2);
    add_frame_a(24'h11, 24'h15, 24'h1);
    add_frame_a(24'h21, 24'h25, 24'h1);
    add_done();
    pulse_start(1'b0);
    run_table(1'b0, "frames2");

    // Only the first line gets data: second line plays blank pixels.
    for (int i = 0; i < 4; i++) q_a.push_back(8'h31 + 8'(i));
    set_cfg(4, 2, 2, 3, 1);
    repeat (2) @(posedge clk);
    add_frame_a(24'h31, 24'h00, 24'h1);
    tbl[9].di = 24'h0; tbl[10].di = 24'h0; tbl[11].di = 24'h0; tbl[12].di = 24'h0;
    add_done();
    pulse_start(1'b0);
    run_table(1'b0, "underrun");
    chk("underrun_flag", {63'h0, ur_a}, 64'h1);

    // Zero blanking, width 1, height 3; a start while busy is ignored.
    for (int i = 0; i < 3; i++) q_a.push_back(8'h41 + 8'(i));
    set_cfg(1, 3, 0, 0, 1);
    repeat (2) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      add(1, 1'b0, 1'b0, 1'b1, 24'h41 + 24'(i), 24'h0);
      add(1, 1'b0, 1'b1, 1'b0, 24'h0, 24'h0);
    end
    add_done();
    tbl[0].st = 1'b1;
    pulse_start(1'b0);
    run_table(1'b0, "zeroblank");
    chk("zeroblank_underrun", {63'h0, ur_a}, 64'h0);

    // 3-byte packing from the prefetched bytes.
    set_cfg(1, 2, 2, 3, 1);
    add_frame_b(24'h030201, 24'h060504);
    add_done();
    pulse_start(1'b1);
    run_table(1'b1, "pack3");
    chk("pack3_underrun", {63'h0, ur_b}, 64'h0);

    // Reset in the middle of a free-running frame.
    set_cfg(1, 2, 2, 3, 0);
    pulse_start(1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk) fe_b = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    q_b.delete();
    for (int i = 0; i < 6; i++) q_b.push_back(8'hA1 + 8'(i));
    @(negedge clk);
    chk("reset_mid_b", {sr_b, busy_b, done_b, vs_b, hs_b, de_b, ur_b, di_b}, 64'h0);
    fe_b = 1'b1;
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done_b) nd++;
    end
    chk("reset_no_done", 64'(nd), 64'h0);
    set_cfg(1, 2, 2, 3, 1);
    add_frame_b(24'hA3A2A1, 24'hA6A5A4);
    add_done();
    pulse_start(1'b1);
    run_table(1'b1, "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/vid_bytestream_src.md
Name: vid_bytestream_src

Overview:
- Synthesizable video stream source that rebuilds the pixel stream a BMP bench produces.
- Accepts a byte stream, LSB first, and packs each group of PIXEL_BYTES bytes into one pixel. Byte n goes to bits [8n+:8].
- Emits the packed pixels as a di/de/hs/vs stream with runtime-configured width, height, blanking and frame count.
- Sits between a frame-store/BMP reader and the filter pipelines under test.

Parameters:
PIXEL_BYTES, 3, bytes per pixel (1..4); output pixel width is 8*PIXEL_BYTES
DIM_W, 13, width of the size/blank config fields (max dimension 8191)
FRM_W, 16, width of the frame counter and cfg_frames

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
cfg_width  in  DIM_W  active pixels per line (>=1)
cfg_height  in  DIM_W  active lines per frame (>=1)
cfg_hblank  in  DIM_W  hblank cycles per line (0 treated as 1)
cfg_vblank  in  DIM_W  vblank cycles before each frame (0 allowed)
cfg_frames  in  FRM_W  frames to emit; 0 = run until reset
start  in  1  one-cycle pulse; sampled only in IDLE
s_data  in  8  input byte
s_valid  in  1  input byte valid
s_ready  out  1  input byte accepted when s_valid&s_ready
di_o  out  8*PIXEL_BYTES  pixel data
de_o  out  1  pixel valid (active region)
hs_o  out  1  high during hblank cycles
vs_o  out  1  high during vblank cycles
busy  out  1  FSM not IDLE
done  out  1  one-cycle pulse after the last requested frame
underrun  out  1  sticky: an active cycle found no pixel ready

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs 0, including s_ready.
  - FSM goes to IDLE; byte counter and pixel register are cleared.
  - A partial pixel is discarded.
  - Reset mid-frame aborts the frame without asserting done.
- cfg_* are latched on the accepted start. Changes while busy have no effect until the next start.
- FSM states:
  - IDLE -> VBLANK on start. If latched vblank=0, go directly to ACTIVE.
  - VBLANK: lasts vblank cycles, then ACTIVE.
  - ACTIVE: lasts width pixel cycles, then HBLANK.
  - HBLANK: lasts hblank cycles. If the line is not the last, go to ACTIVE. If it is the last line, frame_cnt++ and then:
    - cfg_frames!=0 and frame_cnt==cfg_frames: go to IDLE and pulse done.
    - Otherwise: go to VBLANK (or to ACTIVE if vblank=0).
- Outputs are registered. Outputs for a state appear the cycle after the FSM enters it, so start at edge t gives the first vs_o=1 at t+1.
- Exactly one of de_o/hs_o/vs_o is high per busy cycle. All three are 0 in IDLE.
- di_o is 0 whenever de_o=0.
- Packer:
  - The byte counter runs 0..PIXEL_BYTES-1. The assembly register collects bytes.
  - On the last byte the complete pixel moves to the 1-entry pixel register (pix_vld=1).
  - s_ready=1 while the counter < PIXEL_BYTES-1.
  - On the last byte, s_ready=1 only if pix_vld=0 or the pixel is consumed this cycle.
  - The packer accepts bytes in IDLE and blanking too (prefetch).
  - PIXEL_BYTES=1 degenerates to a single register.
- Pixel consumption: each ACTIVE cycle with pix_vld=1 consumes the pixel.
- An ACTIVE cycle with pix_vld=0 is an underrun, handled as set by the optional feature.
- underrun is cleared only by reset or an accepted start.
- Counters are DIM_W wide with compare-to-latched-value. No wrap inside a frame.
- frame_cnt wraps at 2^FRM_W when cfg_frames=0, without side effects.
- start while busy is ignored. start and done never coincide, since done is issued from IDLE entry.

Optional Feature:
- VID_SRC_STALL_EN defined:
  - An ACTIVE cycle with pix_vld=0 holds the pixel counter and outputs de_o=0 (hs_o=vs_o=0).
  - The line resumes when a pixel arrives.
  - underrun is set (flag only) and no data is lost.
- Undefined:
  - The ACTIVE cycle still advances with de_o=1 and di_o=0.
  - underrun is set, and the line length is preserved (fixed timing, as for a display sink).

Test Plan:
- PIXEL_BYTES=3, width=4, height=2, hblank=2, vblank=3, frames=1, bytes 0x01..0x18 streamed with no gaps -> 3 vs cycles, then 4 de, 2 hs, 4 de, 2 hs.
  - di_o = 0x030201, 0x060504, ... 0x181716.
  - done pulses once; busy=0 after; underrun=0.
- Same config, frames=2 -> two identical frames back to back with 3 vblank cycles each; done only after the second frame; total busy cycles = 2*(3+12)=30.
- s_valid held low during the second line -> underrun=1.
  - Stall build: de gaps appear and 8 pixels are eventually emitted.
  - Non-stall build: line 2 is 4 de cycles with di_o=0.
- Backpressure: s_valid=1 constantly from reset release with no start -> exactly PIXEL_BYTES*2-1 bytes accepted (5 for PIXEL_BYTES=3), then s_ready=0 until ACTIVE consumes a pixel.
- rst_n=0 for one cycle mid-line, then start -> all outputs 0 during reset, no done; the new frame's first pixel is built from bytes sent after reset only.
- cfg_vblank=0, cfg_hblank=0, PIXEL_BYTES=1, width=1, height=3 -> pattern de,hs,de,hs,de,hs starting at t+1; start asserted while busy has no effect.
